// File: rtl/uart_host_bridge.sv
// Host-side UART command initiator: sends one opcode/addr/data frame (8N1, LSB first) and checks the reply.
// Latency: 10*CLKS_PER_BIT clocks per sent byte, then the reply bytes; S completes 10*CLKS_PER_BIT clocks after accept.
// Backpressure: req_ready only while idle, one request in flight; rsp_valid is a one-cycle strobe and cannot stall.
// Build option: define UART_HOST_RX_SYNC_EN to pass uart_rx through a 2-flop synchroniser before sampling.
module uart_host_bridge #(
    parameter int CLOCK_FREQ       = 100_000_000,
    parameter int BAUD_RATE        = 115_200,
    parameter int RSP_TIMEOUT_CLKS = 200_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic        uart_tx,
    input  logic        uart_rx
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int TW = $clog2(RSP_TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID      = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [TW-1:0] TO_LAST  = TW'(RSP_TIMEOUT_CLKS - 1);

    localparam logic [7:0] OP_W = 8'h57, OP_R = 8'h52, OP_S = 8'h53;
    localparam logic [7:0] OP_D = 8'h44, OP_P = 8'h50, OP_F = 8'h46;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    op_q, op_d;
    logic [71:0]   frame_q, frame_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [3:0]    tx_left_q, tx_left_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [1:0]    rsp_cnt_q, rsp_cnt_d;
    logic [23:0]   rsp_buf_q, rsp_buf_d;
    logic          rsp_bad_q, rsp_bad_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;

    logic          rx_in;
    logic          rx_prev_q, rx_prev_d;
    logic          rx_act_q, rx_act_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_done, rx_bad;
    logic [7:0]    rx_byte;

    logic [23:0]   buf_new;
    logic          bad_new;
    logic [7:0]    tx_byte;
    logic          tx_line;

    // Number of reply bytes the responder returns for each opcode.
    function automatic logic [1:0] rsp_len(input logic [7:0] op);
        case (op)
            OP_S:             rsp_len = 2'd0;
            OP_R, OP_P, OP_F: rsp_len = 2'd3;
            default:          rsp_len = 2'd1;
        endcase
    endfunction

`ifdef UART_HOST_RX_SYNC_EN
    logic [1:0] rx_sync_q, rx_sync_d;

    // Shift uart_rx through the synchroniser chain.
    always_comb begin
        rx_sync_d = {rx_sync_q[0], uart_rx};
    end

    // Synchroniser flops idle high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) rx_sync_q <= 2'b11;
        else     rx_sync_q <= rx_sync_d;
    end

    assign rx_in = rx_sync_q[1];
`else
    assign rx_in = uart_rx;
`endif

    assign req_ready = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign tx_byte   = frame_q[7:0];
    assign uart_tx   = tx_line;

    // Serial line value for the current bit slot of the byte at the bottom of the frame.
    always_comb begin
        tx_line = 1'b1;
        if (state_q == SEND) begin
            if (tx_bit_q == 4'd0)      tx_line = 1'b0;
            else if (tx_bit_q <= 4'd8) tx_line = tx_byte[3'(tx_bit_q - 4'd1)];
        end
    end

    // RX sampler: runs continuously; falling edge, confirm at mid-start, then one sample per bit time.
    always_comb begin
        rx_prev_d  = rx_in;
        rx_act_d   = rx_act_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        rx_bad     = 1'b0;
        rx_byte    = rx_shift_q;
        if (!rx_act_q) begin
            if (rx_prev_q && !rx_in) begin
                rx_act_d = 1'b1;
                rx_cnt_d = CW'(1);
                rx_bit_d = 4'd0;
            end
        end else if (rx_bit_q == 4'd0) begin
            if (rx_cnt_q >= MID) begin
                rx_cnt_d = '0;
                if (rx_in) rx_act_d = 1'b0;   // glitch, not a start bit
                else       rx_bit_d = 4'd1;
            end else begin
                rx_cnt_d = rx_cnt_q + CW'(1);
            end
        end else if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_d = '0;
            if (rx_bit_q == 4'd9) begin
                rx_act_d = 1'b0;
                rx_done  = 1'b1;
                rx_bad   = !rx_in;
            end else begin
                rx_shift_d = {rx_in, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 4'd1;
            end
        end else begin
            rx_cnt_d = rx_cnt_q + CW'(1);
        end
    end

    // Request FSM: capture, transmit frame, collect and judge reply, strobe result.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        frame_d    = frame_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_left_d  = tx_left_q;
        to_cnt_d   = to_cnt_q;
        rsp_cnt_d  = rsp_cnt_q;
        rsp_buf_d  = rsp_buf_q;
        rsp_bad_d  = rsp_bad_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        buf_new    = rsp_buf_q;
        bad_new    = rsp_bad_q | rx_bad;
        case (rsp_cnt_q)
            2'd0:    buf_new[7:0]   = rx_byte;
            2'd1:    buf_new[15:8]  = rx_byte;
            default: buf_new[23:16] = rx_byte;
        endcase
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_d   = SEND;
                    op_d      = req_op;
                    frame_d   = {req_wdata, req_addr, req_op};
                    tx_cnt_d  = '0;
                    tx_bit_d  = 4'd0;
                    tx_left_d = (req_op == OP_W) ? 4'd9 : (req_op == OP_R) ? 4'd5 : 4'd1;
                    rsp_cnt_d = 2'd0;
                    rsp_buf_d = '0;
                    rsp_bad_d = 1'b0;
                end
            end
            SEND: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 4'd9) begin
                        tx_bit_d  = 4'd0;
                        frame_d   = {8'h00, frame_q[71:8]};
                        tx_left_d = tx_left_q - 4'd1;
                        if (tx_left_q == 4'd1) begin
                            if (op_q == OP_S) begin
                                state_d    = DONE;
                                rsp_data_d = '0;
                                rsp_err_d  = 1'b0;
                            end else begin
                                state_d  = WAIT_RSP;
                                to_cnt_d = '0;
                            end
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            WAIT_RSP: begin
                to_cnt_d = to_cnt_q + TW'(1);
                if (rx_done) begin
                    to_cnt_d  = '0;
                    rsp_buf_d = buf_new;
                    rsp_bad_d = bad_new;
                    rsp_cnt_d = rsp_cnt_q + 2'd1;
                    if (rsp_cnt_q + 2'd1 == rsp_len(op_q)) begin
                        state_d = DONE;
                        case (op_q)
                            OP_W: begin
                                rsp_data_d = '0;
                                rsp_err_d  = bad_new || (rx_byte != 8'h4B);
                            end
                            OP_R, OP_P, OP_F: begin
                                rsp_data_d = {8'h00, buf_new};
                                rsp_err_d  = bad_new;
                            end
                            OP_D: begin
                                rsp_data_d = {31'h0, rx_byte == 8'h31};
                                rsp_err_d  = bad_new || !((rx_byte == 8'h30) || (rx_byte == 8'h31));
                            end
                            default: begin
                                rsp_data_d = {24'h0, rx_byte};
                                rsp_err_d  = bad_new || (rx_byte != 8'h4E);
                            end
                        endcase
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    state_d    = DONE;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            frame_q    <= '0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_left_q  <= '0;
            to_cnt_q   <= '0;
            rsp_cnt_q  <= '0;
            rsp_buf_q  <= '0;
            rsp_bad_q  <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            rx_prev_q  <= 1'b1;
            rx_act_q   <= 1'b0;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            frame_q    <= frame_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_left_q  <= tx_left_d;
            to_cnt_q   <= to_cnt_d;
            rsp_cnt_q  <= rsp_cnt_d;
            rsp_buf_q  <= rsp_buf_d;
            rsp_bad_q  <= rsp_bad_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            rx_prev_q  <= rx_prev_d;
            rx_act_q   <= rx_act_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end
endmodule

// File: tb/tb_uart_host_bridge.sv
// Bench for uart_host_bridge: directed command cases plus randomized requests and responder behaviour.
// Expected frames and results come from a byte-level protocol model; monitors pop and compare independently.
// Every wait is bounded; a global watchdog stops a runaway simulation.
module tb_uart_host_bridge;
    localparam int CF  = 1_000_000;
    localparam int BR  = 100_000;
    localparam int TO  = 500;
    localparam int CPB = CF / BR;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready;
    logic [7:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, busy, uart_tx, uart_rx;
    logic [31:0] rsp_data;

    uart_host_bridge #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .RSP_TIMEOUT_CLKS(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .uart_tx(uart_tx), .uart_rx(uart_rx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        bit          chk_data;
        int          lat_lo;
        int          lat_hi;
    } exp_t;

    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         acc_cyc = 0;
    int         rsp_seen = 0;
    exp_t       rsp_q[$];
    logic [7:0] tx_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    function automatic int n_rsp(input logic [7:0] op);
        if (op == 8'h53) return 0;
        if (op == 8'h52 || op == 8'h50 || op == 8'h46) return 3;
        return 1;
    endfunction

    function automatic int n_tx(input logic [7:0] op);
        if (op == 8'h57) return 9;
        if (op == 8'h52) return 5;
        return 1;
    endfunction

    // Protocol-level expectation for one request given what the responder will send.
    function automatic exp_t model(input logic [7:0] op, input logic [23:0] rb, input int nsend, input int bad_idx);
        exp_t e;
        int   n = n_rsp(op);
        logic [7:0] b0 = rb[7:0];
        e.chk_data = 1'b1;
        e.lat_lo   = 0;
        e.lat_hi   = 0;
        e.data     = 32'h0;
        e.err      = 1'b0;
        if (n == 0) begin
            e.lat_lo = 10 * CPB;
            e.lat_hi = 10 * CPB + 3;
        end else if (nsend < n) begin
            e.err    = 1'b1;
            e.lat_lo = n_tx(op) * 10 * CPB + TO;
            e.lat_hi = e.lat_lo + 2 * (n_tx(op) - 1);
        end else begin
            e.err = (bad_idx >= 0) && (bad_idx < n);
            if (op == 8'h57) begin
                if (b0 != 8'h4B) e.err = 1'b1;
            end else if (n == 3) begin
                e.data = 32'(rb[7:0]) + 32'(rb[15:8]) * 256 + 32'(rb[23:16]) * 65536;
            end else if (op == 8'h44) begin
                if (b0 == 8'h31)      e.data = 32'd1;
                else if (b0 != 8'h30) e.err = 1'b1;
            end else begin
                e.data = 32'(b0);
                if (b0 != 8'h4E) e.err = 1'b1;
            end
            e.chk_data = !e.err;
        end
        return e;
    endfunction

    task automatic push_tx(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd);
        tx_q.push_back(op);
        if (op == 8'h57 || op == 8'h52)
            for (int i = 0; i < 4; i++) tx_q.push_back(8'((addr >> (8 * i)) & 32'hFF));
        if (op == 8'h57)
            for (int i = 0; i < 4; i++) tx_q.push_back(8'((wd >> (8 * i)) & 32'hFF));
    endtask

    task automatic drive_req(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd);
        int w = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 3000) bound_fail("req_ready_wait");
        req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
        req_op    = 8'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        @(negedge clk);
        check("busy_after_accept", busy, 1);
        check("ready_after_accept", req_ready, 0);
    endtask

    // Responder byte; caller is aligned just after a rising edge.
    task automatic send_byte(input logic [7:0] b, input bit bad);
        uart_rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            uart_rx = b[k];
            repeat (CPB) @(posedge clk);
            #1;
        end
        uart_rx = bad ? 1'b0 : 1'b1;
        repeat (CPB) @(posedge clk);
        #1;
        uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [23:0] rb, input int nsend, input int bad_idx);
        int seen0 = rsp_seen;
        int w = 0;
        rsp_q.push_back(model(op, rb, nsend, bad_idx));
        push_tx(op, addr, wd);
        drive_req(op, addr, wd);
        if (nsend > 0) begin
            while (tx_q.size() != 0 && w < 2000) begin
                @(negedge clk);
                w++;
            end
            if (w >= 2000) bound_fail("tx_frame_wait");
            repeat (8) @(posedge clk);
            #1;
            for (int i = 0; i < nsend; i++) send_byte(rb[8*i +: 8], i == bad_idx);
        end
        w = 0;
        while (rsp_seen == seen0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 3000) bound_fail("rsp_valid_wait");
    endtask

    // Response monitor: pops the scoreboard on every rsp_valid strobe.
    initial begin
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                rsp_seen++;
                if (rsp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: rsp_valid with nothing pending, data %h err %b", rsp_data, rsp_err);
                end else begin
                    e   = rsp_q.pop_front();
                    lat = cyc - acc_cyc;
                    if (e.chk_data) check("rsp_data", rsp_data, e.data);
                    check("rsp_err", rsp_err, e.err);
                    if (e.lat_hi > 0) begin
                        if (e.lat_lo == e.lat_hi) check("rsp_latency", lat, e.lat_lo);
                        else check("rsp_latency_in_window", (lat >= e.lat_lo) && (lat <= e.lat_hi), 1);
                    end
                end
                @(negedge clk);
                if (!rst) begin
                    check("rsp_valid_one_cycle", rsp_valid, 0);
                    check("busy_after_done", busy, 0);
                    check("ready_after_done", req_ready, 1);
                end
            end
        end
    end

    // TX monitor: decodes uart_tx bytes; bytes cut short by reset are dropped.
    initial begin
        logic       prev = 1'b1;
        logic [7:0] b;
        logic       st, sp;
        bit         hit;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && uart_tx === 1'b0 && rst !== 1'b1) begin
                hit = 1'b0; b = 8'h00; st = 1'b1; sp = 1'b0;
                for (int i = 1; i <= 94; i++) begin
                    @(negedge clk);
                    if (rst) hit = 1'b1;
                    if (i == 4) st = uart_tx;
                    if (i >= 14 && i <= 84 && (i - 14) % 10 == 0) b[(i - 14) / 10] = uart_tx;
                    if (i == 94) sp = uart_tx;
                end
                if (!hit) begin
                    if (tx_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_tx_byte: got %h with nothing pending", b);
                    end else begin
                        check("tx_start_bit", st, 0);
                        check("tx_byte", b, tx_q.pop_front());
                        check("tx_stop_bit", sp, 1);
                    end
                end
            end
            prev = uart_tx;
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  op;
        logic [23:0] rb;
        int          mode, n, bad;
        rst = 1'b1; req_valid = 1'b0; req_op = 8'h00; req_addr = '0; req_wdata = '0; uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", req_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", req_ready, 1);
        check("reset_uart_tx", uart_tx, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_busy", busy, 0);

        do_req(8'h57, 32'h0000_0010, 32'hDEAD_BEEF, 24'h00004B, 1, -1);
        do_req(8'h52, 32'h0000_0004, $urandom, 24'h345678, 3, -1);
        do_req(8'h52, 32'h0000_0004, $urandom, 24'h332211, 3, 1);
        do_req(8'h44, $urandom, $urandom, 24'h000031, 1, -1);
        do_req(8'h44, $urandom, $urandom, 24'h000032, 1, -1);
        do_req(8'h53, $urandom, $urandom, 24'h0, 0, -1);
        do_req(8'h50, $urandom, $urandom, 24'h0, 0, -1);
        do_req(8'h57, 32'h1234_5678, 32'h0BAD_F00D, 24'h00004B, 1, -1);
        do_req(8'h99, $urandom, $urandom, 24'h00004E, 1, -1);

        // Reset in the middle of byte 3 of a W frame.
        push_tx(8'h57, 32'hA5A5_0001, 32'h5A5A_0002);
        drive_req(8'h57, 32'hA5A5_0001, 32'h5A5A_0002);
        n = 0;
        while (tx_q.size() > 6 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) bound_fail("reset_test_tx_wait");
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("ready_low_in_reset", req_ready, 0);
        @(negedge clk);
        check("abort_uart_tx_high", uart_tx, 1);
        check("abort_busy", busy, 0);
        check("abort_no_rsp_valid", rsp_valid, 0);
        tx_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (150) @(posedge clk);
        do_req(8'h46, $urandom, $urandom, 24'h000002, 3, -1);

        for (int it = 0; it < 16; it++) begin
            case ($urandom_range(0, 6))
                0: op = 8'h57;
                1: op = 8'h52;
                2: op = 8'h53;
                3: op = 8'h44;
                4: op = 8'h50;
                5: op = 8'h46;
                default: begin
                    op = 8'h57;
                    while (op == 8'h57 || op == 8'h52 || op == 8'h53 || op == 8'h44 || op == 8'h50 || op == 8'h46)
                        op = 8'($urandom_range(0, 255));
                end
            endcase
            n    = n_rsp(op);
            mode = $urandom_range(0, 3);
            rb   = 24'($urandom);
            bad  = -1;
            if (mode == 0) begin
                if (op == 8'h57)      rb[7:0] = 8'h4B;
                else if (op == 8'h44) rb[7:0] = ($urandom_range(0, 1) == 1) ? 8'h31 : 8'h30;
                else if (n == 1)      rb[7:0] = 8'h4E;
            end else if (mode == 2 && n > 0) begin
                bad = $urandom_range(0, n - 1);
            end
            do_req(op, $urandom, $urandom, rb, (mode == 3) ? 0 : n, bad);
        end

        repeat (20) @(posedge clk);
        check("rsp_scoreboard_drained", rsp_q.size(), 0);
        check("tx_scoreboard_drained", tx_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
